// File: rtl/y86_mem_pc_stage.sv
// y86_mem_pc_stage
// Y86-64 SEQ back-end slice: decode source selection, byte-addressed data
// memory with address checking, next-PC selection, and the architectural
// PC / status registers.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   icode, ifun         instruction/function codes (ifun is not used here)
//   rA, rB              register fields from fetch
//   valC, valP          constant word and fall-through PC
//   valA, valE          register value read through srcA, ALU result
//   Cnd                 condition result from execute
//   instr_valid         fetch decoded a legal instruction
//   imem_error          fetch address error
//   srcA, srcB          decode source register indices
//   valM                memory read data (0 when not reading or on error)
//   dmem_error          current data access is out of range
//   stat_next           combinational status of the current instruction
//   new_pc              combinational next PC
//   pc, stat            registered PC and processor status
module y86_mem_pc_stage #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic        Cnd,
  input  logic        instr_valid,
  input  logic        imem_error,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [63:0] valM,
  output logic        dmem_error,
  output logic [2:0]  stat_next,
  output logic [63:0] new_pc,
  output logic [63:0] pc,
  output logic [2:0]  stat
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;

  logic [7:0]    mem [MEM_BYTES];
  logic          mem_read;
  logic          mem_write;
  logic [63:0]   mem_addr;
  logic [63:0]   mem_wdata;
  logic [AW-1:0] base;
  logic          commit;
  stat_e         stat_q;
  stat_e         stat_nx;
  logic [63:0]   pc_q;

  // Function code does not steer anything in this slice.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  // Decode source selection
  always_comb begin
    srcA = REG_NONE;
    srcB = REG_NONE;
    case (icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = rA;
      I_RET, I_POPQ:                      srcA = REG_RSP;
      default: ;
    endcase
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcB = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcB = REG_RSP;
      default: ;
    endcase
  end

  // Memory access control
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (icode)
      I_RMMOVQ, I_PUSHQ: begin
        mem_write = 1'b1;
        mem_addr  = valE;
        mem_wdata = valA;
      end
      I_CALL: begin
        mem_write = 1'b1;
        mem_addr  = valE;
        mem_wdata = valP;
      end
      I_MRMOVQ: begin
        mem_read = 1'b1;
        mem_addr = valE;
      end
      I_RET, I_POPQ: begin
        mem_read = 1'b1;
        mem_addr = valA;
      end
      default: ;
    endcase
  end

  // Full 64-bit compare so wrap-around addresses are rejected too.
  assign dmem_error = (mem_read || mem_write) && (mem_addr > 64'(MEM_BYTES - 8));
  assign base       = mem_addr[AW-1:0];

  // Little-endian read; only indexes memory when the whole word is in range.
  always_comb begin
    valM = '0;
    if (mem_read && !dmem_error) begin
      for (int unsigned k = 0; k < 8; k++) begin
        valM[8*k +: 8] = mem[base + AW'(k)];
      end
    end
  end

  // Status generation
  always_comb begin
    stat_nx = STAT_AOK;
    if (imem_error || dmem_error) stat_nx = STAT_ADR;
    else if (!instr_valid)        stat_nx = STAT_INS;
    else if (icode == I_HALT)     stat_nx = STAT_HLT;
  end

  assign stat_next = stat_nx;

  // Next PC
  always_comb begin
    new_pc = valP;
    case (icode)
      I_CALL: new_pc = valC;
      I_JXX:  if (Cnd) new_pc = valC;
      I_RET:  new_pc = valM;
      default: ;
    endcase
  end

  // rst_n is sampled here so a reset overlapping the edge suppresses the write.
  assign commit = mem_write && !dmem_error && (stat_nx == STAT_AOK) && (stat_q == STAT_AOK);

  always_ff @(posedge clk) begin
    if (rst_n && commit) begin
      for (int unsigned k = 0; k < 8; k++) begin
        mem[base + AW'(k)] <= mem_wdata[8*k +: 8];
      end
    end
  end

  // Architectural state: frozen once status leaves AOK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      stat_q <= STAT_AOK;
    end else if (stat_q == STAT_AOK) begin
      stat_q <= stat_nx;
      if (stat_nx == STAT_AOK) pc_q <= new_pc;
    end
  end

  assign pc   = pc_q;
  assign stat = stat_q;

endmodule

// File: tb/tb_y86_mem_pc_stage.sv
// Directed self-checking bench for y86_mem_pc_stage.
module tb_y86_mem_pc_stage;

  logic        clk;
  logic        rst_n;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, valA, valE;
  logic        Cnd, instr_valid, imem_error;
  logic [3:0]  srcA, srcB;
  logic [63:0] valM, new_pc, pc;
  logic        dmem_error;
  logic [2:0]  stat_next, stat;

  int total = 0;
  int bad   = 0;

  y86_mem_pc_stage #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .valA(valA), .valE(valE), .Cnd(Cnd),
    .instr_valid(instr_valid), .imem_error(imem_error), .srcA(srcA), .srcB(srcB),
    .valM(valM), .dmem_error(dmem_error), .stat_next(stat_next), .new_pc(new_pc),
    .pc(pc), .stat(stat)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; icode = 4'h1; ifun = 4'h0; rA = 4'h0; rB = 4'h0;
    valC = '0; valP = '0; valA = '0; valE = '0;
    Cnd = 1'b0; instr_valid = 1'b1; imem_error = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (pc !== 64'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, 64'h0); end
    total++; if (stat !== 3'd1) begin bad++; $display("FAIL reset_stat got=%0d want=%0d", stat, 1); end
    #1 rst_n = 1'b1;
    icode = 4'h1; valP = 64'h2;
    #1;
    total++; if (srcA !== 4'hF) begin bad++; $display("FAIL nop_srcA got=%h want=%h", srcA, 4'hF); end
    total++; if (srcB !== 4'hF) begin bad++; $display("FAIL nop_srcB got=%h want=%h", srcB, 4'hF); end
    step();
    total++; if (pc !== 64'h2) begin bad++; $display("FAIL nop_pc got=%h want=%h", pc, 64'h2); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (pc !== 64'h0) begin bad++; $display("FAIL async_reset_pc got=%h want=%h", pc, 64'h0); end
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    icode = 4'h6; rA = 4'h3; rB = 4'h7;
    #1;
    total++; if (srcA !== 4'h3) begin bad++; $display("FAIL opq_srcA got=%h want=%h", srcA, 4'h3); end
    total++; if (srcB !== 4'h7) begin bad++; $display("FAIL opq_srcB got=%h want=%h", srcB, 4'h7); end
    icode = 4'hB;
    #1;
    total++; if (srcA !== 4'h4) begin bad++; $display("FAIL popq_srcA got=%h want=%h", srcA, 4'h4); end
    total++; if (srcB !== 4'h4) begin bad++; $display("FAIL popq_srcB got=%h want=%h", srcB, 4'h4); end
    icode = 4'h3;
    #1;
    total++; if (srcA !== 4'hF) begin bad++; $display("FAIL irmovq_srcA got=%h want=%h", srcA, 4'hF); end
    total++; if (srcB !== 4'hF) begin bad++; $display("FAIL irmovq_srcB got=%h want=%h", srcB, 4'hF); end
    icode = 4'h4;
    #1;
    total++; if (srcA !== 4'h3) begin bad++; $display("FAIL rmmovq_srcA got=%h want=%h", srcA, 4'h3); end
    total++; if (srcB !== 4'h7) begin bad++; $display("FAIL rmmovq_srcB got=%h want=%h", srcB, 4'h7); end
  endtask

  task automatic test_memory();
    icode = 4'h4; valE = 64'h100; valA = 64'h1122334455667788; valP = 64'h10;
    #1;
    total++; if (dmem_error !== 1'b0) begin bad++; $display("FAIL wr_dmem_error got=%b want=%b", dmem_error, 1'b0); end
    total++; if (stat_next !== 3'd1) begin bad++; $display("FAIL wr_stat_next got=%0d want=%0d", stat_next, 1); end
    step();
    total++; if (pc !== 64'h10) begin bad++; $display("FAIL wr_pc got=%h want=%h", pc, 64'h10); end
    icode = 4'h5; valE = 64'h100; valA = 64'h0; valP = 64'h1A;
    #1;
    total++; if (valM !== 64'h1122334455667788) begin bad++; $display("FAIL mrmovq_valM got=%h want=%h", valM, 64'h1122334455667788); end
    total++; if (dut.mem[256] !== 8'h88) begin bad++; $display("FAIL byte_100 got=%h want=%h", dut.mem[256], 8'h88); end
    total++; if (dut.mem[263] !== 8'h11) begin bad++; $display("FAIL byte_107 got=%h want=%h", dut.mem[263], 8'h11); end
    icode = 4'hB; valA = 64'h100; valE = 64'h0;
    #1;
    total++; if (valM !== 64'h1122334455667788) begin bad++; $display("FAIL popq_valM got=%h want=%h", valM, 64'h1122334455667788); end
    // misaligned push then read back
    icode = 4'hA; valE = 64'h203; valA = 64'hA1B2C3D4E5F60718;
    step();
    icode = 4'h5; valE = 64'h203;
    #1;
    total++; if (valM !== 64'hA1B2C3D4E5F60718) begin bad++; $display("FAIL misaligned_valM got=%h want=%h", valM, 64'hA1B2C3D4E5F60718); end
    total++; if (dut.mem[515] !== 8'h18) begin bad++; $display("FAIL byte_203 got=%h want=%h", dut.mem[515], 8'h18); end
    // highest legal address
    icode = 4'h4; valE = 64'h3F8; valA = 64'h0123456789ABCDEF;
    #1;
    total++; if (dmem_error !== 1'b0) begin bad++; $display("FAIL top_dmem_error got=%b want=%b", dmem_error, 1'b0); end
    step();
    icode = 4'h5; valE = 64'h3F8;
    #1;
    total++; if (valM !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL top_valM got=%h want=%h", valM, 64'h0123456789ABCDEF); end
  endtask

  task automatic test_call_ret();
    icode = 4'h8; valE = 64'h1F8; valP = 64'h40; valC = 64'h80;
    #1;
    total++; if (new_pc !== 64'h80) begin bad++; $display("FAIL call_new_pc got=%h want=%h", new_pc, 64'h80); end
    total++; if (srcB !== 4'h4) begin bad++; $display("FAIL call_srcB got=%h want=%h", srcB, 4'h4); end
    step();
    total++; if (pc !== 64'h80) begin bad++; $display("FAIL call_pc got=%h want=%h", pc, 64'h80); end
    total++; if (dut.mem[504] !== 8'h40) begin bad++; $display("FAIL call_byte got=%h want=%h", dut.mem[504], 8'h40); end
    icode = 4'h9; valA = 64'h1F8; valP = 64'h99; valE = 64'h0;
    #1;
    total++; if (valM !== 64'h40) begin bad++; $display("FAIL ret_valM got=%h want=%h", valM, 64'h40); end
    total++; if (new_pc !== 64'h40) begin bad++; $display("FAIL ret_new_pc got=%h want=%h", new_pc, 64'h40); end
    step();
    total++; if (pc !== 64'h40) begin bad++; $display("FAIL ret_pc got=%h want=%h", pc, 64'h40); end
  endtask

  task automatic test_jump();
    icode = 4'h7; valC = 64'h30; valP = 64'h9; Cnd = 1'b1;
    #1;
    total++; if (new_pc !== 64'h30) begin bad++; $display("FAIL jmp_taken got=%h want=%h", new_pc, 64'h30); end
    Cnd = 1'b0;
    #1;
    total++; if (new_pc !== 64'h9) begin bad++; $display("FAIL jmp_not_taken got=%h want=%h", new_pc, 64'h9); end
    step();
    total++; if (pc !== 64'h9) begin bad++; $display("FAIL jmp_pc got=%h want=%h", pc, 64'h9); end
  endtask

  task automatic test_errors();
    do_reset();
    icode = 4'h1; valP = 64'h24;
    step();
    icode = 4'h5; valE = 64'd1017; valP = 64'h30;
    #1;
    total++; if (dmem_error !== 1'b1) begin bad++; $display("FAIL oob_dmem_error got=%b want=%b", dmem_error, 1'b1); end
    total++; if (valM !== 64'h0) begin bad++; $display("FAIL oob_valM got=%h want=%h", valM, 64'h0); end
    total++; if (stat_next !== 3'd3) begin bad++; $display("FAIL oob_stat_next got=%0d want=%0d", stat_next, 3); end
    step();
    total++; if (stat !== 3'd3) begin bad++; $display("FAIL oob_stat got=%0d want=%0d", stat, 3); end
    total++; if (pc !== 64'h24) begin bad++; $display("FAIL oob_pc got=%h want=%h", pc, 64'h24); end
    // a legal write after the error must not reach memory
    icode = 4'h4; valE = 64'h100; valA = 64'hDEAD; valP = 64'h50;
    step();
    total++; if (stat !== 3'd3) begin bad++; $display("FAIL frozen_stat got=%0d want=%0d", stat, 3); end
    total++; if (pc !== 64'h24) begin bad++; $display("FAIL frozen_pc got=%h want=%h", pc, 64'h24); end
    do_reset();
    icode = 4'h5; valE = 64'h100;
    #1;
    total++; if (valM !== 64'h1122334455667788) begin bad++; $display("FAIL frozen_mem got=%h want=%h", valM, 64'h1122334455667788); end
    icode = 4'h9; valA = 64'hFFFFFFFFFFFFFFFC;
    #1;
    total++; if (dmem_error !== 1'b1) begin bad++; $display("FAIL wrap_dmem_error got=%b want=%b", dmem_error, 1'b1); end
    icode = 4'h1; valE = 64'hFFFFFFFFFFFFFFFF; valA = 64'hFFFFFFFFFFFFFFFF;
    #1;
    total++; if (dmem_error !== 1'b0) begin bad++; $display("FAIL noaccess_dmem_error got=%b want=%b", dmem_error, 1'b0); end
    imem_error = 1'b1;
    #1;
    total++; if (stat_next !== 3'd3) begin bad++; $display("FAIL imem_stat_next got=%0d want=%0d", stat_next, 3); end
    imem_error = 1'b0; instr_valid = 1'b0; valP = 64'h60;
    #1;
    total++; if (stat_next !== 3'd4) begin bad++; $display("FAIL ins_stat_next got=%0d want=%0d", stat_next, 4); end
    step();
    total++; if (stat !== 3'd4) begin bad++; $display("FAIL ins_stat got=%0d want=%0d", stat, 4); end
    total++; if (pc !== 64'h0) begin bad++; $display("FAIL ins_pc got=%h want=%h", pc, 64'h0); end
    instr_valid = 1'b1;
    do_reset();
    icode = 4'h0; valP = 64'h77;
    #1;
    total++; if (stat_next !== 3'd2) begin bad++; $display("FAIL hlt_stat_next got=%0d want=%0d", stat_next, 2); end
    step();
    total++; if (stat !== 3'd2) begin bad++; $display("FAIL hlt_stat got=%0d want=%0d", stat, 2); end
    total++; if (pc !== 64'h0) begin bad++; $display("FAIL hlt_pc got=%h want=%h", pc, 64'h0); end
    icode = 4'h1; valP = 64'h55;
    step();
    step();
    total++; if (stat !== 3'd2) begin bad++; $display("FAIL hlt_sticky_stat got=%0d want=%0d", stat, 2); end
    total++; if (pc !== 64'h0) begin bad++; $display("FAIL hlt_sticky_pc got=%h want=%h", pc, 64'h0); end
  endtask

  task automatic test_reset_write();
    do_reset();
    icode = 4'h4; valE = 64'h300; valA = 64'h5555555555555555; valP = 64'h12;
    step();
    total++; if (pc !== 64'h12) begin bad++; $display("FAIL rw_pc got=%h want=%h", pc, 64'h12); end
    valA = 64'hAAAAAAAAAAAAAAAA;
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    icode = 4'h5;
    #1;
    total++; if (valM !== 64'h5555555555555555) begin bad++; $display("FAIL rw_mem got=%h want=%h", valM, 64'h5555555555555555); end
    total++; if (pc !== 64'h0) begin bad++; $display("FAIL rw_pc_reset got=%h want=%h", pc, 64'h0); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_memory();
    test_call_ret();
    test_jump();
    test_errors();
    test_reset_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y86_mem_pc_stage.md
Name: y86_mem_pc_stage

Overview:
- Combined Y86-64 SEQ back-end slice: decode source-register selection, byte-addressed data memory with status generation, next-PC selection, and the architectural PC/status registers.
- Sits between fetch/execute (which supply icode, rA, rB, valC, valP, valE, valA, Cnd) and the register file. Returns srcA/srcB, valM, the next PC and processor status.

Parameters:
MEM_BYTES, 1024, data memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
icode  in  4  instruction code from fetch.
ifun  in  4  function code; carried for completeness, not used in selection.
rA  in  4  register A field.
rB  in  4  register B field.
valC  in  64  constant word.
valP  in  64  fall-through PC.
valA  in  64  register-file value read through srcA.
valE  in  64  ALU result.
Cnd  in  1  branch/condition result from execute.
instr_valid  in  1  fetch decoded a legal instruction.
imem_error  in  1  fetch address error.
srcA  out  4  decode source A index.
srcB  out  4  decode source B index.
valM  out  64  memory read data.
dmem_error  out  1  current access out of range.
stat_next  out  3  combinational status of current instruction.
new_pc  out  64  combinational next PC.
pc  out  64  registered PC.
stat  out  3  registered processor status.

Behaviour:
- icode encoding:
  - 0 halt, 1 nop, 2 rrmovq/cmov, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
  - RSP = 4; RNONE = F.
- srcA:
  - icode 2, 4, 6, A: rA.
  - icode 9, B: 4.
  - otherwise: F.
- srcB:
  - icode 4, 5, 6: rB.
  - icode 8, 9, A, B: 4.
  - otherwise: F.
- Memory address:
  - icode 4, 5, 8, A: valE.
  - icode 9, B: valA.
  - otherwise: no access.
- Memory write data:
  - icode 4, A: valA.
  - icode 8: valP.
- Access types: read for icode 5, 9, B; write for icode 4, 8, A.
- Memory data format: little-endian 8-byte words at any byte alignment.
- dmem_error: 1 when an access occurs and addr > MEM_BYTES-8, treating addr as unsigned 64-bit and including wrap-around addresses. 0 when there is no access.
- valM:
  - Combinational read of the 8 bytes at addr when reading with no error.
  - Otherwise 0.
- Memory writes:
  - Committed at rising clk only when the access is a write, dmem_error=0, stat_next=1 and stat=1.
  - No partial writes on error.
- stat_next priority:
  - imem_error or dmem_error: 3 (ADR).
  - else instr_valid=0: 4 (INS).
  - else icode=0: 2 (HLT).
  - else: 1 (AOK).
- new_pc:
  - icode 8: valC.
  - icode 7 and Cnd=1: valC.
  - icode 9: valM.
  - otherwise: valP.
- Registers:
  - On rst_n low, pc=0 and stat=1 immediately, regardless of clk.
  - Memory contents are not reset; their value after power-up is undefined until written.
- Each rising clk while stat=1:
  - pc <= new_pc if stat_next=1; otherwise pc holds.
  - stat <= stat_next.
- Once stat is not 1, pc, stat and memory freeze until reset. The status is sticky.
- Reset asserted in the same cycle as a pending write: reset wins and no write occurs.
- All outputs other than pc and stat are purely combinational in the inputs and memory.

Test Plan:
- Reset: rst_n=0 mid-cycle -> pc=0 and stat=1 without a clock edge. Release, icode=1, valP=0x2 -> after one edge pc=2, srcA=srcB=F.
- Decode: icode=6, rA=3, rB=7 -> srcA=3, srcB=7. icode=B -> srcA=4, srcB=4. icode=3 -> srcA=F, srcB=F.
- Memory round trip:
  - icode=4, valE=0x100, valA=0x1122334455667788, edge.
  - Then icode=5, valE=0x100 -> valM=0x1122334455667788 and byte 0x100 holds 0x88.
  - icode=B, valA=0x100 -> same valM.
- Call/ret: icode=8, valE=0x1F8, valP=0x40, valC=0x80 -> new_pc=0x80 and mem[0x1F8]=0x40 after the edge. Then icode=9, valA=0x1F8 -> new_pc=0x40.
- Jump: icode=7, valC=0x30, valP=0x9. Cnd=1 -> new_pc=0x30; Cnd=0 -> new_pc=0x9.
- Errors:
  - icode=5, valE=MEM_BYTES-7 -> dmem_error=1, valM=0, stat_next=3, and after the edge stat=3 with pc frozen.
  - After reset, instr_valid=0 -> stat=4.
  - After reset, icode=0 -> stat=2 and later edges change nothing.
